// File: rtl/vinsn_scoreboard.sv
// Vector instruction scoreboard: tracks up to MaxInflight issued vector
// instructions and stalls issue on table-full, duplicate-ID and RAW/WAW/WAR
// register hazards. Entries retire on done pulses and are dropped by flush.
module vinsn_scoreboard #(
    parameter  int unsigned NrVReg      = 32,
    parameter  int unsigned MaxInflight = 4,
    parameter  int unsigned IdWidth     = 3,
    localparam int unsigned VRegW       = $clog2(NrVReg),
    localparam int unsigned CntW        = $clog2(MaxInflight + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [VRegW-1:0]   issue_vd_i,
    input  logic               issue_vd_we_i,
    input  logic [VRegW-1:0]   issue_vs1_i,
    input  logic               issue_vs1_re_i,
    input  logic [VRegW-1:0]   issue_vs2_i,
    input  logic               issue_vs2_re_i,
    input  logic               done_valid_i,
    input  logic [IdWidth-1:0] done_id_i,
    output logic [CntW-1:0]    inflight_cnt_o,
    output logic               empty_o,
    output logic [NrVReg-1:0]  busy_vreg_o,
    output logic               unknown_done_o
);

    // Table storage: valid bits are reset, payload is only meaningful when valid.
    logic [MaxInflight-1:0] valid_q, valid_d;
    logic [IdWidth-1:0]     id_q  [MaxInflight];
    logic [VRegW-1:0]       vd_q  [MaxInflight];
    logic [VRegW-1:0]       vs1_q [MaxInflight];
    logic [VRegW-1:0]       vs2_q [MaxInflight];
    logic [MaxInflight-1:0] we_q, re1_q, re2_q;

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   unknown_q, unknown_d;

    logic [MaxInflight-1:0] entryHazard;
    logic [MaxInflight-1:0] doneMatch;
    logic [MaxInflight-1:0] freeSlot;
    logic                   freeFound;
    logic                   accept;

    // Per-entry conflict of the offered insn against the registered table only.
    always_comb begin
        entryHazard = '0;
        for (int e = 0; e < MaxInflight; e++) begin
            entryHazard[e] = valid_q[e] & (
                  (issue_vs1_re_i & we_q[e]  & (issue_vs1_i == vd_q[e]))
                | (issue_vs2_re_i & we_q[e]  & (issue_vs2_i == vd_q[e]))
                | (issue_vd_we_i  & we_q[e]  & (issue_vd_i  == vd_q[e]))
                | (issue_vd_we_i  & re1_q[e] & (issue_vd_i  == vs1_q[e]))
                | (issue_vd_we_i  & re2_q[e] & (issue_vd_i  == vs2_q[e]))
                | (issue_id_i == id_q[e]));
        end
    end

    // One-hot pick of the lowest-index free entry for the next accepted insn.
    always_comb begin
        freeSlot  = '0;
        freeFound = 1'b0;
        for (int e = 0; e < MaxInflight; e++) begin
            if (!valid_q[e] && !freeFound) begin
                freeSlot[e] = 1'b1;
                freeFound   = 1'b1;
            end
        end
    end

    // Locate the entry retired by this cycle's done pulse (IDs are unique in the table).
    always_comb begin
        doneMatch = '0;
        for (int e = 0; e < MaxInflight; e++) begin
            doneMatch[e] = done_valid_i & valid_q[e] & (done_id_i == id_q[e]);
        end
    end

    assign issue_ready_o = !rst_i && !flush_i
                         && (cnt_q < CntW'(MaxInflight))
                         && !(|entryHazard);
    assign accept        = issue_valid_i & issue_ready_o;

    // Next-state for valid bits, occupancy count and the sticky unknown-done flag.
    always_comb begin
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        unknown_d = unknown_q;
        if (flush_i) begin
            valid_d = '0;
            cnt_d   = '0;
        end else begin
            valid_d = (valid_q & ~doneMatch) | ({MaxInflight{accept}} & freeSlot);
            cnt_d   = cnt_q + CntW'(accept) - CntW'(|doneMatch);
            if (done_valid_i && !(|doneMatch)) begin
                unknown_d = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset so the table empties immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            cnt_q     <= '0;
            unknown_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            unknown_q <= unknown_d;
        end
    end

    // Payload capture into the chosen free entry when an insn is accepted.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < MaxInflight; e++) begin
            if (accept && freeSlot[e]) begin
                id_q[e]  <= issue_id_i;
                vd_q[e]  <= issue_vd_i;
                we_q[e]  <= issue_vd_we_i;
                vs1_q[e] <= issue_vs1_i;
                re1_q[e] <= issue_vs1_re_i;
                vs2_q[e] <= issue_vs2_i;
                re2_q[e] <= issue_vs2_re_i;
            end
        end
    end

    // Destination registers claimed by valid writing entries.
    always_comb begin
        busy_vreg_o = '0;
        for (int e = 0; e < MaxInflight; e++) begin
            if (valid_q[e] && we_q[e]) begin
                busy_vreg_o[vd_q[e]] = 1'b1;
            end
        end
    end

    assign inflight_cnt_o = cnt_q;
    assign empty_o        = (cnt_q == '0);
    assign unknown_done_o = unknown_q;

endmodule
